// File: rtl/addsub_seq.sv
// Multi-cycle add/subtract unit: walks the operands CHUNK bits per clock with a
// registered carry between chunks, and hands results over on a valid/ready handshake.
module addsub_seq #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Negative,
  output logic             Carry,
  output logic             Overflow
);

  localparam int N  = (CHUNK > 0) ? WIDTH / CHUNK : 1;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  generate
    if (CHUNK < 1 || CHUNK > WIDTH || ((CHUNK < 1) ? 1 : (WIDTH % CHUNK)) != 0) begin : g_bad_params
      $error("addsub_seq: CHUNK must divide WIDTH and satisfy 1 <= CHUNK <= WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] bx_q;       // B already inverted for subtract
  logic             cy_q;
  logic [KW-1:0]    k_q;
  logic             last_chunk;
  logic [CHUNK:0]   sum;
  logic [WIDTH-1:0] result_d;

  assign last_chunk = (k_q == KW'(N - 1));

  always_comb begin
    sum      = {1'b0, a_q[int'(k_q) * CHUNK +: CHUNK]}
             + {1'b0, bx_q[int'(k_q) * CHUNK +: CHUNK]}
             + {{CHUNK{1'b0}}, cy_q};
    result_d = Result;
    result_d[int'(k_q) * CHUNK +: CHUNK] = sum[CHUNK-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: default assignment first so no path through the case leaves
  // state_d unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)   state_d = BUSY;
      BUSY:    if (last_chunk) state_d = DONE;
      DONE:    if (out_ready)  state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      bx_q     <= '0;
      cy_q     <= 1'b0;
      k_q      <= '0;
      Result   <= '0;
      Zero     <= 1'b0;
      Negative <= 1'b0;
      Carry    <= 1'b0;
      Overflow <= 1'b0;
    end else begin
      if (state_q == IDLE && in_valid) begin
        a_q  <= A;
        bx_q <= Op ? ~B : B;
        cy_q <= Op;
        k_q  <= '0;
      end else if (state_q == BUSY) begin
        Result <= result_d;
        cy_q   <= sum[CHUNK];
        k_q    <= k_q + KW'(1);
        if (last_chunk) begin
          Carry    <= sum[CHUNK];
          Zero     <= (result_d == '0);
          Negative <= result_d[WIDTH-1];
          Overflow <= (a_q[WIDTH-1] == bx_q[WIDTH-1]) && (result_d[WIDTH-1] != a_q[WIDTH-1]);
        end
      end
    end
  end

endmodule

// File: tb/tb_addsub_seq.sv
// Directed bench for addsub_seq: vector table on a 16-bit-chunk instance plus
// handshake, reset-abort and single-cycle (CHUNK=WIDTH) sequences.
module tb_addsub_seq;

  typedef struct {
    logic        op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] res;
    logic        z, n, c, v;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, op = 1'b0, out_ready = 1'b0;
  logic [63:0] a = '0, b = '0;
  logic        in_ready, out_valid, zero, negative, carry, overflow;
  logic [63:0] result;

  logic        w_in_valid = 1'b0, w_op = 1'b0, w_out_ready = 1'b0;
  logic [63:0] w_a = '0, w_b = '0;
  logic        w_in_ready, w_out_valid, w_zero, w_negative, w_carry, w_overflow;
  logic [63:0] w_result;

  int total = 0;
  int bad   = 0;
  vec_t vecs[9];

  always #5 clk = ~clk;

  addsub_seq #(.WIDTH(64), .CHUNK(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .Op(op),
    .A(a), .B(b), .out_valid(out_valid), .out_ready(out_ready), .Result(result),
    .Zero(zero), .Negative(negative), .Carry(carry), .Overflow(overflow)
  );

  addsub_seq #(.WIDTH(64), .CHUNK(64)) dut_wide (
    .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready), .Op(w_op),
    .A(w_a), .B(w_b), .out_valid(w_out_valid), .out_ready(w_out_ready), .Result(w_result),
    .Zero(w_zero), .Negative(w_negative), .Carry(w_carry), .Overflow(w_overflow)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic o, input logic [63:0] x, input logic [63:0] y);
    int guard = 0;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    check("in_ready before accept", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1;
    op = o;
    a = x;
    b = y;
    tick();
    in_valid = 1'b0;
    a = 64'hDEAD_BEEF_DEAD_BEEF;
    b = 64'h0BAD_F00D_0BAD_F00D;
    op = ~o;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (lat <= 20) begin
      tick();
      if (out_valid) return;
      lat++;
    end
    lat = -1;
  endtask

  task automatic check_outs(input string tag, input vec_t v);
    check({tag, " result"},   result, v.res);
    check({tag, " zero"},     {63'd0, zero},     {63'd0, v.z});
    check({tag, " negative"}, {63'd0, negative}, {63'd0, v.n});
    check({tag, " carry"},    {63'd0, carry},    {63'd0, v.c});
    check({tag, " overflow"}, {63'd0, overflow}, {63'd0, v.v});
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("out_valid after handshake", {63'd0, out_valid}, 64'd0);
    check("in_ready after handshake",  {63'd0, in_ready},  64'd1);
  endtask

  task automatic apply(input string tag, input vec_t v);
    int lat;
    start_op(v.op, v.a, v.b);
    wait_done(lat);
    check({tag, " latency"}, 64'(lat), 64'd4);
    check_outs(tag, v);
    finish_op();
  endtask

  initial begin
    int lat;
    //          op    a                      b                      result                 z     n     c     v
    vecs[0] = '{1'b1, 64'd5,                 64'd3,                 64'd2,                 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 64'hA,                 64'h14,                64'hFFFFFFFFFFFFFFF6,  1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 64'd0,                 64'd1,                 64'hFFFFFFFFFFFFFFFF,  1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 64'h8000000000000000,  64'd1,                 64'h7FFFFFFFFFFFFFFF,  1'b0, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{1'b0, 64'hFFFFFFFFFFFFFFFF,  64'd1,                 64'd0,                 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 64'h7FFFFFFFFFFFFFFF,  64'd1,                 64'h8000000000000000,  1'b0, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 64'd5,                 64'd5,                 64'd0,                 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 64'h0000FFFF0000FFFF,  64'h0000000100000001,  64'h0001000000010000,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 64'h123456789ABCDEF0,  64'd1,                 64'h123456789ABCDEF1,  1'b0, 1'b0, 1'b0, 1'b0};

    // Reset values while rst_n is low.
    #2;
    check("reset in_ready",  {63'd0, in_ready},  64'd1);
    check("reset out_valid", {63'd0, out_valid}, 64'd0);
    check("reset result",    result, 64'd0);
    check("reset flags",     {60'd0, zero, negative, carry, overflow}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) apply($sformatf("vec%0d", i), vecs[i]);

    // Backpressure: result held, new operands ignored while DONE.
    start_op(1'b1, 64'd5, 64'd3);
    wait_done(lat);
    check("bp latency", 64'(lat), 64'd4);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      op = 1'b0;
      a = 64'd100 + 64'(i);
      b = 64'd200;
      tick();
      check("bp out_valid held", {63'd0, out_valid}, 64'd1);
      check("bp in_ready low",   {63'd0, in_ready},  64'd0);
      check_outs("bp", vecs[0]);
    end
    in_valid = 1'b0;
    finish_op();
    check("bp result kept in idle", result, 64'd2);
    tick();
    check("bp no stray accept", {63'd0, in_ready}, 64'd1);

    // Reset two cycles into BUSY aborts, then a clean operation follows.
    start_op(1'b1, 64'd5, 64'd3);
    tick();
    tick();
    check("pre-abort busy", {62'd0, in_ready, out_valid}, 64'd0);
    rst_n = 1'b0;
    #1;
    check("abort in_ready",  {63'd0, in_ready},  64'd1);
    check("abort out_valid", {63'd0, out_valid}, 64'd0);
    check("abort result",    result, 64'd0);
    check("abort flags",     {60'd0, zero, negative, carry, overflow}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    apply("post-reset", vecs[8]);

    // Single-chunk instance: one-cycle latency.
    w_in_valid = 1'b1;
    w_op = 1'b1;
    w_a = 64'd5;
    w_b = 64'd3;
    tick();
    w_in_valid = 1'b0;
    w_a = '0;
    w_b = '0;
    lat = 1;
    tick();
    while (!w_out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("wide latency", 64'(lat), 64'd1);
    check("wide result", w_result, 64'd2);
    check("wide flags", {60'd0, w_zero, w_negative, w_carry, w_overflow}, 64'b0010);
    w_out_ready = 1'b1;
    tick();
    w_out_ready = 1'b0;
    check("wide handshake", {62'd0, w_in_ready, w_out_valid}, 64'b10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
